// File: rtl/threshold_pkg.sv
// Shared types and default screen geometry for the threshold selector.
// Holds the selector state enum and the default parameter values used by
// threshold_selector; no ports.
package threshold_pkg;

    typedef enum logic [1:0] {
        ST_SELECT = 2'd0,
        ST_ADJUST = 2'd1,
        ST_LOCKED = 2'd2
    } sel_state_e;

    localparam int DEF_NUM_BOXES   = 4;
    localparam int DEF_PIXEL_WIDTH = 12;
    localparam int DEF_THRESH_STEP = 800;
    localparam int DEF_ADJ_STEP    = 16;

    localparam int DEF_BOX_X0      = 8;
    localparam int DEF_BOX_Y0      = 200;
    localparam int DEF_BOX_W       = 240;
    localparam int DEF_BOX_H       = 320;
    localparam int DEF_BOX_GAP     = 16;
    localparam int DEF_ARROW_Y     = 560;
    localparam int DEF_ARROW_SIZE  = 100;

endpackage

// File: rtl/button_edge_detect.sv
// Turns a debounced button level into a single-cycle press pulse.
//   clk_in    : pixel clock
//   rst_n_in  : synchronous active-low reset
//   level_in  : debounced button level
//   pulse_out : high for the cycle in which level_in is first seen high
module button_edge_detect (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic level_in,
    output logic pulse_out
);

    logic prev_q;
    // armed_q stays low for the first cycle after reset so a button held
    // through reset is absorbed into prev_q instead of reading as a press.
    logic armed_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= level_in;
            armed_q <= 1'b1;
        end
    end

    assign pulse_out = armed_q & level_in & ~prev_q;

endmodule

// File: rtl/threshold_selector.sv
// Threshold preview selector: NUM_BOXES side-by-side preview boxes each show
// the frame buffer thresholded at that box's own level. Left/right move the
// selection arrow (SELECT) or nudge the selected threshold (ADJUST); confirm
// cycles SELECT -> ADJUST -> LOCKED -> SELECT.
//   clk_in, rst_n_in            : pixel clock, synchronous active-low reset
//   hcount_in, vcount_in        : raster position
//   left_in/right_in/confirm_in : debounced button levels
//   frame_buff_in               : grayscale pixel at the raster position
//   pixel_out, arrow_out        : registered video outputs (1-cycle latency)
//   select_out, threshold_out   : selected box and its live threshold
//   locked_out                  : high while LOCKED
module threshold_selector
    import threshold_pkg::*;
#(
    parameter int NUM_BOXES   = DEF_NUM_BOXES,
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int THRESH_STEP = DEF_THRESH_STEP,
    parameter int ADJ_STEP    = DEF_ADJ_STEP,
    parameter int BOX_X0      = DEF_BOX_X0,
    parameter int BOX_Y0      = DEF_BOX_Y0,
    parameter int BOX_W       = DEF_BOX_W,
    parameter int BOX_H       = DEF_BOX_H,
    parameter int BOX_GAP     = DEF_BOX_GAP,
    parameter int ARROW_Y     = DEF_ARROW_Y,
    parameter int ARROW_SIZE  = DEF_ARROW_SIZE
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [10:0]                  hcount_in,
    input  logic [9:0]                   vcount_in,
    input  logic                         left_in,
    input  logic                         right_in,
    input  logic                         confirm_in,
    input  logic [PIXEL_WIDTH-1:0]       frame_buff_in,
    output logic                         pixel_out,
    output logic                         arrow_out,
    output logic [$clog2(NUM_BOXES)-1:0] select_out,
    output logic [PIXEL_WIDTH-1:0]       threshold_out,
    output logic                         locked_out
);

    localparam int SEL_W     = $clog2(NUM_BOXES);
    localparam int BOX_PITCH = BOX_W + BOX_GAP;

    localparam logic [SEL_W-1:0]       SEL_LAST = SEL_W'(NUM_BOXES - 1);
    localparam logic [PIXEL_WIDTH:0]   ADJ      = (PIXEL_WIDTH+1)'(ADJ_STEP);
    localparam logic [PIXEL_WIDTH-1:0] PIX_MAX  = '1;

    localparam logic [31:0] ROW_LO   = 32'(BOX_Y0);
    localparam logic [31:0] ROW_HI   = 32'(BOX_Y0 + BOX_H);
    localparam logic [31:0] ARW_X0   = 32'(BOX_X0 + BOX_W/2 - ARROW_SIZE/2);
    localparam logic [31:0] ARW_PIT  = 32'(BOX_PITCH);
    localparam logic [31:0] ARW_LEN  = 32'(ARROW_SIZE);
    localparam logic [31:0] ARW_Y_LO = 32'(ARROW_Y);
    localparam logic [31:0] ARW_Y_HI = 32'(ARROW_Y + ARROW_SIZE);

    // ---------------- button presses ----------------
    logic left_p, right_p, confirm_p;

    button_edge_detect u_left    (.clk_in(clk_in), .rst_n_in(rst_n_in), .level_in(left_in),    .pulse_out(left_p));
    button_edge_detect u_right   (.clk_in(clk_in), .rst_n_in(rst_n_in), .level_in(right_in),   .pulse_out(right_p));
    button_edge_detect u_confirm (.clk_in(clk_in), .rst_n_in(rst_n_in), .level_in(confirm_in), .pulse_out(confirm_p));

    // Simultaneous left+right cancel each other.
    logic go_left, go_right;
    assign go_left  = left_p  & ~right_p;
    assign go_right = right_p & ~left_p;

    // ---------------- FSM ----------------
    sel_state_e state_q, state_d;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) state_q <= ST_SELECT;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (confirm_p) begin
            case (state_q)
                ST_SELECT: state_d = ST_ADJUST;
                ST_ADJUST: state_d = ST_LOCKED;
                default:   state_d = ST_SELECT;
            endcase
        end
    end

    // ---------------- selection and live thresholds ----------------
    logic [SEL_W-1:0]                        sel_q;
    logic [NUM_BOXES-1:0][PIXEL_WIDTH-1:0]   thresh_q;
    logic [PIXEL_WIDTH-1:0]                  cur_thr;
    logic [PIXEL_WIDTH:0]                    thr_sum, thr_dif;
    logic [PIXEL_WIDTH-1:0]                  thr_up, thr_dn;

    // One extra bit so overflow/underflow shows up as the carry/borrow.
    assign cur_thr = thresh_q[sel_q];
    assign thr_sum = {1'b0, cur_thr} + ADJ;
    assign thr_dif = {1'b0, cur_thr} - ADJ;
    assign thr_up  = thr_sum[PIXEL_WIDTH] ? PIX_MAX : thr_sum[PIXEL_WIDTH-1:0];
    assign thr_dn  = thr_dif[PIXEL_WIDTH] ? '0      : thr_dif[PIXEL_WIDTH-1:0];

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sel_q <= '0;
            for (int i = 0; i < NUM_BOXES; i++)
                thresh_q[i] <= PIXEL_WIDTH'((i + 1) * THRESH_STEP);
        end else begin
            case (state_q)
                ST_SELECT: begin
                    if (go_right)     sel_q <= (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
                    else if (go_left) sel_q <= (sel_q == '0) ? SEL_LAST : sel_q - SEL_W'(1);
                end
                ST_ADJUST: begin
                    if (go_right)     thresh_q[sel_q] <= thr_up;
                    else if (go_left) thresh_q[sel_q] <= thr_dn;
                end
                default: ;
            endcase
        end
    end

    // ---------------- frame-start snapshot ----------------
    // Drawing uses copies taken at (0,0) so edits never tear a frame.
    logic                                  frame_start;
    logic [NUM_BOXES-1:0][PIXEL_WIDTH-1:0] shadow_q;
    logic [SEL_W-1:0]                      sel_frame_q;

    assign frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sel_frame_q <= '0;
            for (int i = 0; i < NUM_BOXES; i++)
                shadow_q[i] <= PIXEL_WIDTH'((i + 1) * THRESH_STEP);
        end else if (frame_start) begin
            sel_frame_q <= sel_q;
            shadow_q    <= thresh_q;
        end
    end

    // ---------------- raster geometry ----------------
    logic [31:0]          hx, vy;
    logic                 in_rows;
    logic [NUM_BOXES-1:0] hit;

    assign hx      = 32'(hcount_in);
    assign vy      = 32'(vcount_in);
    assign in_rows = (vy >= ROW_LO) && (vy < ROW_HI);

    for (genvar i = 0; i < NUM_BOXES; i++) begin : g_box
        localparam logic [31:0] XS = 32'(BOX_X0 + i * BOX_PITCH);
        localparam logic [31:0] XE = 32'(BOX_X0 + i * BOX_PITCH + BOX_W);
        assign hit[i] = in_rows && (hx >= XS) && (hx < XE) && (frame_buff_in >= shadow_q[i]);
    end

    logic [31:0] arw_left;
    logic        in_arrow;

    assign arw_left = ARW_X0 + 32'(sel_frame_q) * ARW_PIT;
    assign in_arrow = (hx >= arw_left) && (hx < arw_left + ARW_LEN) &&
                      (vy >= ARW_Y_LO) && (vy < ARW_Y_HI);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            pixel_out <= 1'b0;
            arrow_out <= 1'b0;
        end else begin
            pixel_out <= |hit;
            arrow_out <= in_arrow && (state_q != ST_LOCKED);
        end
    end

    assign select_out    = sel_q;
    assign threshold_out = cur_thr;
    assign locked_out    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_threshold_selector.sv
module tb_threshold_selector;

    localparam int NB   = 4;
    localparam int PW   = 12;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [10:0]   hcount;
    logic [9:0]    vcount;
    logic          left, right, confirm;
    logic [PW-1:0] fb;
    logic          pixel, arrow, locked;
    logic [1:0]    sel;
    logic [PW-1:0] thr;

    threshold_selector dut (
        .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .left_in(left), .right_in(right), .confirm_in(confirm),
        .frame_buff_in(fb), .pixel_out(pixel), .arrow_out(arrow),
        .select_out(sel), .threshold_out(thr), .locked_out(locked)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // State: 0 select, 1 adjust, 2 locked.
    int m_thr[NB], m_shadow[NB];
    int m_sel, m_sel_frame, m_state;
    bit m_prev[3];
    bit m_armed, m_valid = 0;
    int e_pix, e_arr;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                m_thr[i]    = (i + 1) * 800;
                m_shadow[i] = (i + 1) * 800;
            end
            m_sel = 0; m_sel_frame = 0; m_state = 0;
            m_prev = '{0, 0, 0}; m_armed = 0;
            e_pix = 0; e_arr = 0;
            m_valid = 1;
        end else begin
            int h, v, ax;
            bit pl, pr, pc;
            h = hcount; v = vcount;
            e_pix = 0;
            for (int i = 0; i < NB; i++) begin
                int xs;
                xs = 8 + i * 256;
                if (h >= xs && h < xs + 240 && v >= 200 && v < 520)
                    e_pix = (int'(fb) >= m_shadow[i]) ? 1 : 0;
            end
            ax = 8 + m_sel_frame * 256 + 120 - 50;
            e_arr = (m_state != 2 && h >= ax && h < ax + 100 && v >= 560 && v < 660) ? 1 : 0;
            if (h == 0 && v == 0) begin
                m_shadow = m_thr;
                m_sel_frame = m_sel;
            end
            pl = m_armed && left    && !m_prev[0];
            pr = m_armed && right   && !m_prev[1];
            pc = m_armed && confirm && !m_prev[2];
            m_prev = '{left, right, confirm};
            m_armed = 1;
            if (pl != pr) begin
                if (m_state == 0)
                    m_sel = pr ? (m_sel + 1) % NB : (m_sel + NB - 1) % NB;
                else if (m_state == 1)
                    m_thr[m_sel] = pr ? ((m_thr[m_sel] + 16 > PMAX) ? PMAX : m_thr[m_sel] + 16)
                                      : ((m_thr[m_sel] < 16) ? 0 : m_thr[m_sel] - 16);
            end
            if (pc) m_state = (m_state + 1) % 3;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_pixel",  int'(pixel),  e_pix);
            chk("model_arrow",  int'(arrow),  e_arr);
            chk("model_select", int'(sel),    m_sel);
            chk("model_thresh", int'(thr),    m_thr[m_sel]);
            chk("model_locked", int'(locked), (m_state == 2) ? 1 : 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // b: 0 left, 1 right, 2 confirm, 3 left+right together
    task automatic press(input int b);
        left    = (b == 0 || b == 3);
        right   = (b == 1 || b == 3);
        confirm = (b == 2);
        tick(2);
        left = 0; right = 0; confirm = 0;
        tick(1);
    endtask

    task automatic pos(input int h, input int v, input int p);
        hcount = 11'(h); vcount = 10'(v); fb = PW'(p);
        tick(1);
    endtask

    int sel_seq[4] = '{1, 2, 3, 0};

    initial begin
        rst_n = 0; left = 0; right = 1; confirm = 0;
        hcount = 11'd1500; vcount = 10'd900; fb = '0;
        tick(3);
        rst_n = 1;
        tick(2);
        right = 0;
        tick(1);
        chk("reset_select", int'(sel), 0);
        chk("reset_thresh", int'(thr), 800);
        chk("reset_locked", int'(locked), 0);
        chk("reset_pixel",  int'(pixel), 0);
        chk("reset_arrow",  int'(arrow), 0);

        for (int k = 0; k < 4; k++) begin
            press(1);
            chk("sel_right", int'(sel), sel_seq[k]);
        end
        press(0);
        chk("sel_left_wrap", int'(sel), 3);
        press(3);
        chk("sel_both_ignored", int'(sel), 3);

        press(2);
        chk("adjust_not_locked", int'(locked), 0);
        chk("box3_thresh", int'(thr), 3200);
        repeat (60) press(1);
        chk("thresh_sat_hi", int'(thr), 4095);
        press(0);
        chk("thresh_after_left", int'(thr), 4079);

        press(2);
        chk("locked_on", int'(locked), 1);
        press(1);
        chk("locked_ignore_thr", int'(thr), 4079);
        chk("locked_ignore_sel", int'(sel), 3);

        // sel_frame is still 0 here, so (78,560) would be inside the arrow
        pos(78, 560, 0);
        chk("arrow_locked", int'(arrow), 0);

        press(2);
        chk("unlock", int'(locked), 0);
        press(1);
        chk("sel_wrap_0", int'(sel), 0);
        pos(0, 0, 0);
        pos(78, 560, 0);   chk("arrow_left_edge", int'(arrow), 1);
        pos(77, 560, 0);   chk("arrow_before",    int'(arrow), 0);
        pos(177, 659, 0);  chk("arrow_far_corner", int'(arrow), 1);
        pos(178, 560, 0);  chk("arrow_after",     int'(arrow), 0);
        pos(100, 660, 0);  chk("arrow_below",     int'(arrow), 0);

        pos(100, 300, 900);
        chk("pix_900_vs_800", int'(pixel), 1);
        press(2);
        repeat (8) press(1);
        chk("box0_thresh_928", int'(thr), 928);
        chk("pix_no_tear", int'(pixel), 1);
        pos(0, 0, 0);
        pos(100, 300, 900);  chk("pix_after_frame", int'(pixel), 0);
        pos(100, 300, 928);  chk("pix_equal",       int'(pixel), 1);
        pos(100, 300, 927);  chk("pix_below",       int'(pixel), 0);
        pos(7, 300, 4095);   chk("pix_left_out",    int'(pixel), 0);
        pos(248, 300, 4095); chk("pix_right_out",   int'(pixel), 0);
        pos(8, 200, 4095);   chk("pix_tl_corner",   int'(pixel), 1);
        pos(247, 519, 4095); chk("pix_br_corner",   int'(pixel), 1);
        pos(100, 520, 4095); chk("pix_bottom_out",  int'(pixel), 0);
        pos(264, 300, 1599); chk("pix_box1_below",  int'(pixel), 0);
        pos(264, 300, 1600); chk("pix_box1_equal",  int'(pixel), 1);

        press(1);
        press(1);
        hcount = 11'd100; vcount = 10'd300; fb = PW'(900);
        rst_n = 0;
        tick(2);
        rst_n = 1;
        tick(2);
        chk("rst2_locked", int'(locked), 0);
        chk("rst2_select", int'(sel), 0);
        chk("rst2_thr0",   int'(thr), 800);
        chk("rst2_pixel",  int'(pixel), 1);
        press(1); chk("rst2_thr1", int'(thr), 1600);
        press(1); chk("rst2_thr2", int'(thr), 2400);
        press(1); chk("rst2_thr3", int'(thr), 3200);
        press(2);
        press(1);
        chk("rst2_select_state", int'(sel), 3);
        chk("rst2_adjust_state", int'(thr), 3216);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
